// File: rtl/retire_unit_pkg.sv
// rtl/retire_unit_pkg.sv - shared types for the in-order retire stage
package retire_unit_pkg;

    // One reorder-buffer entry as presented in the head window.
    typedef struct packed {
        logic [31:0] pc;
        logic        dest_reg_valid;
        logic [4:0]  dest_reg;
        logic [31:0] result_lo;
        logic [31:0] result_hi;
        logic        hilo_wr;
        logic        exc;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RS_RUN,
        RS_EXC,
        RS_FLUSHWAIT
    } retire_state_t;

    localparam logic [4:0] GPR_ZERO = 5'd0;

endpackage

// File: rtl/retire_select.sv
// rtl/retire_select.sv - head-window retire count, exception index and write masks
module retire_select
    import retire_unit_pkg::*;
#(
    parameter  int EXT_COUNT    = 4,
    parameter  int DEPTH        = 16,
    localparam int DEPTHLOG2    = $clog2(DEPTH),
    localparam int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  rob_entry_t              slot_data [EXT_COUNT],
    input  logic                    slot_valid [EXT_COUNT],
    input  logic [DEPTHLOG2:0]      rob_used_count,
    output logic [EXTCOUNTLOG2:0]   ret_n,
    output logic                    exc_found,
    output logic [EXTCOUNTLOG2-1:0] exc_idx,
    output logic                    wr_mask [EXT_COUNT],
    output logic                    hilo_found,
    output logic [EXTCOUNTLOG2-1:0] hilo_idx
);

    logic stop;
    logic in_win;

    // Count the leading run of retire-eligible entries; the first blocker may be an exception.
    always_comb begin
        ret_n     = '0;
        exc_found = 1'b0;
        exc_idx   = '0;
        stop      = 1'b0;
        in_win    = 1'b0;
        for (int k = 0; k < EXT_COUNT; k++) begin
            // Entries at or beyond the occupancy count carry stale valid bits.
            in_win = int'(rob_used_count) > k;
            if (!stop) begin
                if (in_win && slot_valid[k] && !slot_data[k].exc) begin
                    ret_n = ret_n + (EXTCOUNTLOG2+1)'(1);
                end else begin
                    stop = 1'b1;
                    if (in_win && slot_valid[k] && slot_data[k].exc) begin
                        exc_found = 1'b1;
                        exc_idx   = EXTCOUNTLOG2'(k);
                    end
                end
            end
        end
    end

    // GPR lane enables: an older lane is masked when a younger retiring lane writes the same register.
    always_comb begin
        for (int k = 0; k < EXT_COUNT; k++) begin
            wr_mask[k] = 1'b0;
        end
        for (int k = 0; k < EXT_COUNT; k++) begin
            if (k < int'(ret_n) && slot_data[k].dest_reg_valid && slot_data[k].dest_reg != GPR_ZERO) begin
                wr_mask[k] = 1'b1;
                for (int j = k + 1; j < EXT_COUNT; j++) begin
                    if (j < int'(ret_n) && slot_data[j].dest_reg_valid &&
                        slot_data[j].dest_reg == slot_data[k].dest_reg) begin
                        wr_mask[k] = 1'b0;
                    end
                end
            end
        end
    end

    // HI/LO source: the youngest retiring entry that writes HI/LO.
    always_comb begin
        hilo_found = 1'b0;
        hilo_idx   = '0;
        for (int k = 0; k < EXT_COUNT; k++) begin
            if (k < int'(ret_n) && slot_data[k].hilo_wr) begin
                hilo_found = 1'b1;
                hilo_idx   = EXTCOUNTLOG2'(k);
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - in-order commit stage behind the reorder buffer
module retire_unit
    import retire_unit_pkg::*;
#(
    parameter  int EXT_COUNT    = 4,
    parameter  int DEPTH        = 16,
    localparam int DEPTHLOG2    = $clog2(DEPTH),
    localparam int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  rob_entry_t              slot_data [EXT_COUNT],
    input  logic                    slot_valid [EXT_COUNT],
    input  logic                    rob_empty,
    input  logic [DEPTHLOG2:0]      rob_used_count,
    input  logic                    stall,
    output logic                    consume,
    output logic [EXTCOUNTLOG2-1:0] consume_count,
    output logic                    rf_wr_en [EXT_COUNT],
    output logic [4:0]              rf_wr_reg [EXT_COUNT],
    output logic [31:0]             rf_wr_data [EXT_COUNT],
    output logic                    hilo_wr_en,
    output logic [31:0]             hi_data,
    output logic [31:0]             lo_data,
    output logic                    exc_valid,
    output logic [31:0]             exc_pc,
    input  logic                    exc_ack,
    output logic [31:0]             retired_count
);

    retire_state_t             state;
    logic [EXTCOUNTLOG2:0]     ret_n;
    logic                      exc_found;
    logic [EXTCOUNTLOG2-1:0]   exc_idx;
    logic                      wr_mask [EXT_COUNT];
    logic                      hilo_found;
    logic [EXTCOUNTLOG2-1:0]   hilo_idx;
    logic                      run_ok;
    logic                      do_retire;
    logic                      take_exc;

    retire_select #(
        .EXT_COUNT (EXT_COUNT),
        .DEPTH     (DEPTH)
    ) u_select (
        .slot_data      (slot_data),
        .slot_valid     (slot_valid),
        .rob_used_count (rob_used_count),
        .ret_n          (ret_n),
        .exc_found      (exc_found),
        .exc_idx        (exc_idx),
        .wr_mask        (wr_mask),
        .hilo_found     (hilo_found),
        .hilo_idx       (hilo_idx)
    );

    // Stall dominates: with stall high neither retirement nor exception entry happens.
    assign run_ok        = (state == RS_RUN) && !stall && !rob_empty;
    assign do_retire     = run_ok && (ret_n != '0);
    assign take_exc      = run_ok && exc_found;
    assign consume       = do_retire;
    assign consume_count = do_retire ? EXTCOUNTLOG2'(ret_n - (EXTCOUNTLOG2+1)'(1)) : '0;

    // Exception sequencing: hold the report until acknowledged, then wait for the flush to drain the ROB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RS_RUN;
            exc_valid <= 1'b0;
            exc_pc    <= '0;
        end else begin
            case (state)
                RS_RUN: begin
                    if (take_exc) begin
                        state     <= RS_EXC;
                        exc_valid <= 1'b1;
                        exc_pc    <= slot_data[exc_idx].pc;
                    end
                end
                RS_EXC: begin
                    if (exc_ack) begin
                        state     <= RS_FLUSHWAIT;
                        exc_valid <= 1'b0;
                    end
                end
                RS_FLUSHWAIT: begin
                    if (rob_empty) begin
                        state <= RS_RUN;
                    end
                end
                default: state <= RS_RUN;
            endcase
        end
    end

    // Architectural-state writes land one cycle after the consume handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < EXT_COUNT; k++) begin
                rf_wr_en[k]   <= 1'b0;
                rf_wr_reg[k]  <= '0;
                rf_wr_data[k] <= '0;
            end
            hilo_wr_en    <= 1'b0;
            hi_data       <= '0;
            lo_data       <= '0;
            retired_count <= '0;
        end else begin
            for (int k = 0; k < EXT_COUNT; k++) begin
                rf_wr_en[k] <= do_retire && wr_mask[k];
                if (do_retire) begin
                    rf_wr_reg[k]  <= slot_data[k].dest_reg;
                    rf_wr_data[k] <= slot_data[k].result_lo;
                end
            end
            hilo_wr_en <= do_retire && hilo_found;
            if (do_retire && hilo_found) begin
                hi_data <= slot_data[hilo_idx].result_hi;
                lo_data <= slot_data[hilo_idx].result_lo;
            end
            if (do_retire) begin
                retired_count <= retired_count + 32'(ret_n);
            end
        end
    end

endmodule
